// File: rtl/bus_arbiter.sv
// Round-robin arbiter and master-side multiplexer for the shared system bus.
// Four masters request with active-low lines; the owner keeps the bus until it
// withdraws its request, and its address/strobe/rw/write data drive the slaves.
// Optional feature macro: ARB_TIMEOUT_EN (revokes a grant held too long).
module bus_arbiter #(
  parameter int unsigned N_MASTERS      = 4,
  parameter int unsigned ADDR_W         = 30,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_MASTERS-1:0]          m_req_,
  output logic [N_MASTERS-1:0]          m_grnt_,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS-1:0]          m_as_,
  input  logic [N_MASTERS-1:0]          m_rw,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wr_data,
  output logic [ADDR_W-1:0]             s_addr,
  output logic                          s_as_,
  output logic                          s_rw,
  output logic [DATA_W-1:0]             s_wr_data,
  output logic                          arb_timeout
);

  localparam int unsigned IDX_W = 2;

  // Only the four-master configuration is implemented
  if (N_MASTERS != 4) begin : g_bad_n
    $error("bus_arbiter supports N_MASTERS == 4 only");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_to
    $error("bus_arbiter requires TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       owner, owner_nxt;
  logic [IDX_W-1:0]       last_owner, last_owner_nxt;
  logic [N_MASTERS-1:0]   req;
  logic [IDX_W:0]         pick;
  logic                   expired;
  logic                   hold_c;
  logic                   timeout_c;

  // First active requester scanning cyclically from start; msb flags a hit
  function automatic logic [IDX_W:0] rr_pick(input logic [N_MASTERS-1:0] r,
                                             input logic [IDX_W-1:0]     start);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] idx;
    res = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      idx = start + IDX_W'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign req    = ~m_req_;
  assign hold_c = (state == GRANT) && req[owner] && !expired;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt;

  assign expired = (state == GRANT) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Ownership age: cleared on any change of owner, counts while held
  always_ff @(posedge clk) begin
    if (reset)       cnt <= '0;
    else if (hold_c) cnt <= cnt + CNT_W'(1);
    else             cnt <= '0;
  end
`else
  assign expired = 1'b0;
`endif

  // Next owner selection: fresh arbitration from IDLE, handoff on release/revoke
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    timeout_c      = 1'b0;
    pick           = '0;
    case (state)
      IDLE: begin
        pick = rr_pick(req, last_owner + IDX_W'(1));
        if (pick[IDX_W]) begin
          state_nxt = GRANT;
          owner_nxt = pick[IDX_W-1:0];
        end
      end
      GRANT: begin
        if (!hold_c) begin
          // A revoked owner is still requesting; keep it out of this round
          timeout_c      = req[owner];
          last_owner_nxt = owner;
          pick           = rr_pick(req & ~(N_MASTERS'(1) << owner), owner + IDX_W'(1));
          if (pick[IDX_W]) begin
            owner_nxt = pick[IDX_W-1:0];
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, registered grant lines and timeout pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= '0;
      last_owner  <= IDX_W'(N_MASTERS - 1);
      m_grnt_     <= '1;
      arb_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      last_owner  <= last_owner_nxt;
      m_grnt_     <= (state_nxt == GRANT) ? ~(N_MASTERS'(1) << owner_nxt) : '1;
      arb_timeout <= timeout_c;
    end
  end

  // Slave-side mux from the registered owner; idle bus is a parked READ
  always_comb begin
    s_addr    = '0;
    s_as_     = 1'b1;
    s_rw      = 1'b1;
    s_wr_data = '0;
    if (state == GRANT) begin
      s_addr    = m_addr[owner*ADDR_W +: ADDR_W];
      s_as_     = m_as_[owner];
      s_rw      = m_rw[owner];
      s_wr_data = m_wr_data[owner*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed vector table, corner sequences and
// randomized traffic checked against a behavioural round-robin model.
module tb_bus_arbiter;

  localparam int unsigned TO = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   m_req_;
  logic [3:0]   m_grnt_;
  logic [119:0] m_addr;
  logic [3:0]   m_as_;
  logic [3:0]   m_rw;
  logic [127:0] m_wr_data;
  logic [29:0]  s_addr;
  logic         s_as_;
  logic         s_rw;
  logic [31:0]  s_wr_data;
  logic         arb_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner index (-1 = nobody), previous owner, hold age
  int   mdl_owner = -1;
  int   mdl_last  = 3;
  int   mdl_cnt   = 0;
  logic mdl_to    = 1'b0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] grnt;
  } vec_t;

  vec_t vecs[$];

  bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .m_req_      (m_req_),
    .m_grnt_     (m_grnt_),
    .m_addr      (m_addr),
    .m_as_       (m_as_),
    .m_rw        (m_rw),
    .m_wr_data   (m_wr_data),
    .s_addr      (s_addr),
    .s_as_       (s_as_),
    .s_rw        (s_rw),
    .s_wr_data   (s_wr_data),
    .arb_timeout (arb_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rr(input logic [3:0] req_n, input int start, input int excl);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (start + k) % 4;
      if (!req_n[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model(input logic rst, input logic [3:0] req_n);
    mdl_to = 1'b0;
    if (rst) begin
      mdl_owner = -1;
      mdl_last  = 3;
      mdl_cnt   = 0;
    end else if (mdl_owner < 0) begin
      mdl_owner = rr(req_n, (mdl_last + 1) % 4, -1);
      mdl_cnt   = 0;
    end else if (req_n[mdl_owner]) begin
      mdl_last  = mdl_owner;
      mdl_owner = rr(req_n, (mdl_owner + 1) % 4, -1);
      mdl_cnt   = 0;
    end
`ifdef ARB_TIMEOUT_EN
    else if (mdl_cnt == int'(TO) - 1) begin
      mdl_last  = mdl_owner;
      mdl_owner = rr(req_n, (mdl_owner + 1) % 4, mdl_last);
      mdl_to    = 1'b1;
      mdl_cnt   = 0;
    end
`endif
    else begin
      mdl_cnt++;
    end
  endtask

  task automatic check_all();
    logic [3:0] eg;
    eg = 4'hF;
    if (mdl_owner >= 0) eg = ~(4'b0001 << mdl_owner);
    chk("grant", 128'(m_grnt_), 128'(eg));
    chk("grant_onehot", 128'($countones(~m_grnt_) <= 1), 128'(1));
    chk("arb_timeout", 128'(arb_timeout), 128'(mdl_to));
    if (mdl_owner < 0) begin
      chk("s_addr_idle", 128'(s_addr), 128'(0));
      chk("s_as_idle", 128'(s_as_), 128'(1));
      chk("s_rw_idle", 128'(s_rw), 128'(1));
      chk("s_wr_data_idle", 128'(s_wr_data), 128'(0));
    end else begin
      chk("s_addr", 128'(s_addr), 128'(m_addr[mdl_owner*30 +: 30]));
      chk("s_as_", 128'(s_as_), 128'(m_as_[mdl_owner]));
      chk("s_rw", 128'(s_rw), 128'(m_rw[mdl_owner]));
      chk("s_wr_data", 128'(s_wr_data), 128'(m_wr_data[mdl_owner*32 +: 32]));
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare just after it
  task automatic step(input logic rst, input logic [3:0] req, input logic [3:0] as_n);
    reset     = rst;
    m_req_    = req;
    m_as_     = as_n;
    m_rw      = 4'($urandom);
    m_addr    = 120'({$urandom, $urandom, $urandom, $urandom});
    m_wr_data = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    model(rst, req);
    #1;
    check_all();
  endtask

  task automatic add(input logic rst, input logic [3:0] req, input logic [3:0] grnt);
    vec_t v;
    v.rst  = rst;
    v.req  = req;
    v.grnt = grnt;
    vecs.push_back(v);
  endtask

  initial begin
    int hold_n;
    int to_at;
    logic [3:0] to_grnt;
    logic [3:0] rq;

    reset = 1'b1; m_req_ = 4'hF; m_as_ = 4'hF; m_rw = 4'hF;
    m_addr = '0; m_wr_data = '0;

    step(1'b1, 4'hF, 4'hF);
    step(1'b1, 4'hF, 4'hF);
    chk("reset_grant", 128'(m_grnt_), 128'(4'hF));
    chk("reset_as", 128'(s_as_), 128'(1));

`ifdef ARB_TIMEOUT_EN
    hold_n = 6;
`else
    hold_n = 10;
`endif
    add(1'b0, 4'b1110, 4'b1110);
    for (int i = 0; i < hold_n; i++) add(1'b0, 4'b0000, 4'b1110);
    add(1'b0, 4'b0001, 4'b1101);
    add(1'b0, 4'b0010, 4'b1011);
    add(1'b0, 4'b0100, 4'b0111);
    add(1'b0, 4'b1000, 4'b1110);
    add(1'b0, 4'b1111, 4'b1111);
    add(1'b0, 4'b1011, 4'b1011);
    add(1'b0, 4'b1111, 4'b1111);
    add(1'b0, 4'b0101, 4'b0111);
    add(1'b0, 4'b1111, 4'b1111);
    add(1'b0, 4'b1101, 4'b1101);
    add(1'b1, 4'b1101, 4'b1111);
    add(1'b0, 4'b0000, 4'b1110);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req, 4'b0000);
      chk($sformatf("vec%0d_grant", i), 128'(m_grnt_), 128'(vecs[i].grnt));
      if (i == 0) chk("vec0_s_addr", 128'(s_addr), 128'(m_addr[29:0]));
      if (vecs[i].rst) chk("reset_mid_xfer_as", 128'(s_as_), 128'(1));
    end
    step(1'b0, 4'hF, 4'hF);

`ifdef ARB_TIMEOUT_EN
    // Master 0 holds while master 1 waits: revoke after TO granted cycles
    to_at = -1;
    to_grnt = 4'hF;
    step(1'b0, 4'b1110, 4'b0000);
    for (int c = 1; c <= 12; c++) begin
      step(1'b0, 4'b1100, 4'b0000);
      if (arb_timeout && to_at < 0) begin
        to_at = c;
        to_grnt = m_grnt_;
      end
    end
    chk("timeout_cycle", 128'(to_at), 128'(TO));
    chk("timeout_grant", 128'(to_grnt), 128'(4'b1101));
    step(1'b0, 4'hF, 4'hF);
`endif

    // Randomized traffic with sticky requests and occasional reset
    rq = 4'hF;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(3) == 0) rq[b] = ~rq[b];
      step(($urandom_range(63) == 0), rq, 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
